// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin head arbitration with packet locking.
// Grants are combinational from current lock state; state advances on the next edge.
module switch_allocator #(
  parameter int         NUM_PORTS = 5,
  parameter logic [2:0] RR_RESET  = 3'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_valid,
  input  logic [2:0]           op_port0,
  input  logic [2:0]           op_port1,
  input  logic [2:0]           op_port2,
  input  logic [2:0]           op_port3,
  input  logic [2:0]           op_port4,
  input  logic [1:0]           flit_type0,
  input  logic [1:0]           flit_type1,
  input  logic [1:0]           flit_type2,
  input  logic [1:0]           flit_type3,
  input  logic [1:0]           flit_type4,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic [NUM_PORTS-1:0] grant,
  output logic [2:0]           xbar_sel0,
  output logic [2:0]           xbar_sel1,
  output logic [2:0]           xbar_sel2,
  output logic [2:0]           xbar_sel3,
  output logic [2:0]           xbar_sel4,
  output logic [NUM_PORTS-1:0] xbar_valid,
  output logic                 proto_err
);
  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_RSVD = 2'b11;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  logic [NUM_PORTS-1:0][2:0]           w_op;
  logic [NUM_PORTS-1:0][1:0]           w_ft;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_req;    // [output][input]
  logic [NUM_PORTS-1:0]                w_locked;
  logic [NUM_PORTS-1:0][2:0]           w_owner;
  logic [NUM_PORTS-1:0]                w_win_vld;
  logic [NUM_PORTS-1:0][2:0]           w_win_idx;
  logic [NUM_PORTS-1:0]                w_err;
  logic                                r_err;

  assign w_op = {op_port4, op_port3, op_port2, op_port1, op_port0};
  assign w_ft = {flit_type4, flit_type3, flit_type2, flit_type1, flit_type0};

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_req_o
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req_i
      assign w_req[o][i] = req_valid[i] && (w_op[i] == 3'(o)) && (w_ft[i] != FT_RSVD);
    end
  end

  // Per-output lock state and arbitration
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    state_t     r_state;
    logic [2:0] r_owner;
    logic [2:0] r_rr;
    logic       w_vld;
    logic [2:0] w_idx;
    logic [2:0] w_cand;

    always_comb begin
      w_vld  = 1'b0;
      w_idx  = '0;
      w_cand = '0;
      if (r_state == S_IDLE) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          w_cand = 3'((int'(r_rr) + k) % NUM_PORTS);
          if (!w_vld && w_req[o][w_cand] && w_ft[w_cand] == FT_HEAD) begin
            w_vld = 1'b1;
            w_idx = w_cand;
          end
        end
      end else if (w_req[o][r_owner] &&
                   (w_ft[r_owner] == FT_BODY || w_ft[r_owner] == FT_TAIL)) begin
        w_vld = 1'b1;
        w_idx = r_owner;
      end
      if (!out_ready[o] || !rst) w_vld = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= S_IDLE;
        r_owner <= '0;
        r_rr    <= RR_RESET;
      end else if (w_vld) begin
        if (r_state == S_IDLE) begin
          r_state <= S_LOCKED;
          r_owner <= w_idx;
          r_rr    <= (w_idx == 3'(NUM_PORTS-1)) ? 3'd0 : 3'(w_idx + 3'd1);
        end else if (w_ft[w_idx] == FT_TAIL) begin
          r_state <= S_IDLE;
        end
      end
    end

    assign w_locked[o]  = (r_state == S_LOCKED);
    assign w_owner[o]   = r_owner;
    assign w_win_vld[o] = w_vld;
    assign w_win_idx[o] = w_vld ? w_idx : 3'd0;
  end

  // Protocol checks per input; offending inputs are never eligible above
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chk
    always_comb begin
      w_err[i] = 1'b0;
      if (req_valid[i]) begin
        if (int'(w_op[i]) >= NUM_PORTS || w_ft[i] == FT_RSVD)
          w_err[i] = 1'b1;
        else if (!w_locked[w_op[i]])
          w_err[i] = (w_ft[i] != FT_HEAD);
        else if (w_owner[w_op[i]] == 3'(i))
          w_err[i] = (w_ft[i] == FT_HEAD);
        else
          w_err[i] = (w_ft[i] != FT_HEAD);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_err <= 1'b0;
    else if (|w_err) r_err <= 1'b1;
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      if (w_win_vld[o]) grant[w_win_idx[o]] = 1'b1;
  end

  assign xbar_valid = w_win_vld;
  assign xbar_sel0  = w_win_idx[0];
  assign xbar_sel1  = w_win_idx[1];
  assign xbar_sel2  = w_win_idx[2];
  assign xbar_sel3  = w_win_idx[3];
  assign xbar_sel4  = w_win_idx[4];
  assign proto_err  = r_err;
endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of router ports; ports 0 local, 1 north, 2 east, 3 south, 4 west.
REQ-002 SHALL have parameter RR_RESET, default 0, reset value of every round-robin pointer.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid  input  5  bit i: input buffer i holds a flit at its head.
REQ-006 SHALL have ports op_port0..op_port4  input  3 each  output port computed by route_compute for input i; 0-4 legal, 5-7 illegal.
REQ-007 SHALL have ports flit_type0..flit_type4  input  2 each  head-flit type of input i: 00 head, 01 body, 10 tail, 11 reserved.
REQ-008 SHALL have port out_ready  input  5  bit o: downstream of output o can accept one flit this cycle.
REQ-009 SHALL have port grant  output  5  bit i: input i dequeues and traverses the crossbar this cycle.
REQ-010 SHALL have ports xbar_sel0..xbar_sel4  output  3 each  input index driving output o.
REQ-011 SHALL have port xbar_valid  output  5  bit o: output o carries a flit this cycle.
REQ-012 SHALL have port proto_err  output  1  sticky protocol-error flag.

Function
REQ-013 Each output o SHALL hold a state register {IDLE, LOCKED}, a 3-bit owner register and a 3-bit rr_ptr.
REQ-014 grant, xbar_sel, xbar_valid SHALL be combinational from current state and same-cycle inputs; allocation latency is zero cycles, and state updates on the next edge.
REQ-015 Input i SHALL request output o when req_valid[i], op_port_i==o and flit_type_i!=11.
REQ-016 IDLE: eligible inputs are those requesting o with head type; the winner is the first eligible in order rr_ptr, rr_ptr+1, ... wrapping mod 5.
REQ-017 IDLE grant SHALL occur only when out_ready[o]=1; no grant means no state change and no pointer change.
REQ-018 On an IDLE head grant to input i: state->LOCKED, owner<=i, rr_ptr<=(i+1) mod 5, with 4->0 wrap.
REQ-019 LOCKED: only owner is eligible; it is granted when it requests o with body or tail and out_ready[o]=1.
REQ-020 On a LOCKED tail grant, state SHALL return to IDLE at the next edge; rr_ptr is unchanged.
REQ-021 Non-owner requests to a LOCKED output SHALL wait, with no grant and no error, for head flits.
REQ-022 SHALL set proto_err and grant nothing in any of these cases: body/tail to an IDLE output; body/tail from a non-owner; head from the owner of a LOCKED output; op_port 5-7 with req_valid; type 11 with req_valid.
REQ-023 For each o, xbar_valid[o]=1 iff some input is granted for o; xbar_sel_o = that input index, else 0.
REQ-024 At most one grant per output and per input per cycle; grant[i]=1 implies exactly one xbar_valid bit with xbar_sel==i.
REQ-025 A packet SHALL never be interleaved: output o carries only owner flits from head grant through tail grant inclusive.
REQ-026 out_ready low mid-packet SHALL stall without releasing the lock.
REQ-027 proto_err SHALL clear only on reset.

Reset
REQ-028 rst low SHALL immediately, asynchronously, force all outputs IDLE, owners 0, rr_ptr=RR_RESET, proto_err 0.
REQ-029 During reset grant, xbar_valid and xbar_sel SHALL be 0.
REQ-030 Reset mid-packet SHALL drop all locks; the first post-reset flit must be a head, else proto_err.

Verification
REQ-031 Single packet: input 0 head op_port 2, then body, body, tail, out_ready=11111 -> grant[0] 4 consecutive cycles, xbar_valid[2]=1, xbar_sel2=0, output 2 IDLE after tail.
REQ-032 Contention: inputs 1 and 3 heads to output 4 same cycle, rr_ptr 0 -> input 1 wins, rr_ptr becomes 2, input 3 waits until input 1 tail, then granted; input 1 next head loses to a waiting input 3.
REQ-033 Backpressure: out_ready[1]=0 for 3 cycles mid-packet from input 2 -> grant[2]=0, xbar_valid[1]=0 those cycles, lock held, resumes in order.
REQ-034 Parallel: inputs 0-4 heads to distinct outputs 4,3,2,1,0 -> all five grants same cycle, xbar_sel4=0 ... xbar_sel0=4.
REQ-035 Errors: body flit to IDLE output, op_port=6 -> no grant, proto_err=1 and held until rst.
REQ-036 Reset mid-packet after head+body -> locks cleared, body afterwards -> proto_err; fresh head -> granted.
